// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between a requester and the
// ALU operation sequencer.
interface alu_op_sequencer_if #(
  parameter int data_width = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_func;
  logic [data_width-1:0] req_a;
  logic [data_width-1:0] req_b;
  logic                  req_use_acc;
  logic                  req_acc_wr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [data_width-1:0] resp_data;
  logic                  resp_overflow;

  modport master (
    output req_valid, req_func, req_a, req_b,
    output req_use_acc, req_acc_wr, resp_ready,
    input  req_ready, resp_valid, resp_data,
    input  resp_overflow
  );

  modport slave (
    input  req_valid, req_func, req_a, req_b,
    input  req_use_acc, req_acc_wr, resp_ready,
    output req_ready, resp_valid, resp_data,
    output resp_overflow
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives a shared combinational ALU: registers operands, captures the
// result a cycle later, returns it with accumulator/sticky/count state.
module alu_op_sequencer #(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  alu_op_sequencer_if.slave     bus,
  output logic [data_width-1:0] acc_out,
  output logic                  sticky_ovf,
  input  logic                  sticky_clr,
  output logic [data_width-1:0] op_count,
  output logic [data_width-1:0] alu_a,
  output logic [data_width-1:0] alu_b,
  output logic [3:0]            alu_func,
  input  logic [data_width-1:0] alu_c,
  input  logic                  alu_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_next;
  logic   acc_wr;
  logic   take;
  logic   done;

  localparam logic [data_width-1:0] count_max = '1;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next     = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    take           = 1'b0;
    done           = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          take       = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand issue to the ALU; held between operations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_func <= 4'b0000;
      acc_wr   <= 1'b0;
    end else if (take) begin
      alu_a    <= bus.req_use_acc ? acc_out : bus.req_a;
      alu_b    <= bus.req_b;
      alu_func <= bus.req_func;
      acc_wr   <= bus.req_acc_wr;
    end
  end

  // Result capture and accumulator update at the end of EXEC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.resp_data     <= '0;
      bus.resp_overflow <= 1'b0;
      acc_out           <= '0;
    end else if (state == EXEC) begin
      bus.resp_data     <= alu_c;
      bus.resp_overflow <= alu_ovf;
      if (acc_wr) acc_out <= alu_c;
    end
  end

  // Sticky overflow; a capture that overflows beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     sticky_ovf <= 1'b0;
    else if (state == EXEC && alu_ovf) sticky_ovf <= 1'b1;
    else if (sticky_clr)              sticky_ovf <= 1'b0;
  end

  // Saturating count of delivered responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      op_count <= '0;
    else if (done && op_count != count_max)
      op_count <= op_count + 1'b1;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 16-bit ALU
// attached to the alu_* ports.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] acc_out;
  logic        sticky_ovf;
  logic        sticky_clr;
  logic [15:0] op_count;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_func;
  logic [15:0] alu_c;
  logic        alu_ovf;

  int errors = 0;
  int checks = 0;

  alu_op_sequencer_if #(.data_width(16)) bus ();

  alu_op_sequencer #(.data_width(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .acc_out    (acc_out),
    .sticky_ovf (sticky_ovf),
    .sticky_clr (sticky_clr),
    .op_count   (op_count),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .alu_c      (alu_c),
    .alu_ovf    (alu_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: signed overflow on ADD/SUB only.
  always_comb begin
    logic [15:0] r;
    r       = 16'h0000;
    alu_ovf = 1'b0;
    case (alu_func)
      4'b0000: begin
        r       = alu_a + alu_b;
        alu_ovf = (alu_a[15] == alu_b[15]) && (r[15] != alu_a[15]);
      end
      4'b0001: begin
        r       = alu_a - alu_b;
        alu_ovf = (alu_a[15] != alu_b[15]) && (r[15] != alu_a[15]);
      end
      4'b0010: r = alu_a;
      4'b0011: r = ~alu_a;
      4'b0100: r = alu_a & alu_b;
      4'b0101: r = alu_a | alu_b;
      4'b0110: r = ~(alu_a & alu_b);
      4'b0111: r = ~(alu_a | alu_b);
      default: r = 16'h0000;
    endcase
    alu_c = r;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [3:0]  f,
                           input logic [15:0] a,
                           input logic [15:0] b,
                           input logic        ua,
                           input logic        aw);
    bus.req_valid   = 1'b1;
    bus.req_func    = f;
    bus.req_a       = a;
    bus.req_b       = b;
    bus.req_use_acc = ua;
    bus.req_acc_wr  = aw;
  endtask

  // Full op with resp_ready high; returns the response seen in RESP.
  task automatic do_op(input  string       tag,
                       input  logic [3:0]  f,
                       input  logic [15:0] a,
                       input  logic [15:0] b,
                       input  logic        ua,
                       input  logic        aw,
                       output logic [15:0] data,
                       output logic        ovf);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check({tag, "_rdy_timeout"}, 0, 1);
    drive_req(f, a, b, ua, aw);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, "_exec_vld"}, bus.resp_valid, 0);
    @(negedge clk);
    check({tag, "_resp_vld"}, bus.resp_valid, 1);
    data = bus.resp_data;
    ovf  = bus.resp_overflow;
    @(negedge clk);
  endtask

  logic [15:0] d;
  logic        o;
  int          pulses;

  initial begin
    reset_n         = 1'b0;
    sticky_clr      = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_func    = 4'h0;
    bus.req_a       = 16'h0;
    bus.req_b       = 16'h0;
    bus.req_use_acc = 1'b0;
    bus.req_acc_wr  = 1'b0;
    bus.resp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_acc", acc_out, 0);
    check("rst_count", op_count, 0);
    check("rst_func", alu_func, 0);
    check("rst_sticky", sticky_ovf, 0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op("add", 4'b0000, 16'h7FFF, 16'h0001, 0, 0, d, o);
    check("add_data", d, 16'h8000);
    check("add_ovf", o, 1);
    check("add_sticky", sticky_ovf, 1);
    check("add_count", op_count, 1);

    do_op("sub", 4'b0001, 16'h0005, 16'h0007, 0, 0, d, o);
    check("sub_data", d, 16'hFFFE);
    check("sub_ovf", o, 0);
    check("sub_sticky", sticky_ovf, 1);
    check("sub_count", op_count, 2);

    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check("clr_sticky", sticky_ovf, 0);

    do_op("acc0", 4'b0010, 16'h0003, 16'h0000, 0, 1, d, o);
    check("acc0_data", d, 16'h0003);
    do_op("acc1", 4'b0000, 16'hDEAD, 16'h0004, 1, 1, d, o);
    check("acc1_data", d, 16'h0007);
    do_op("acc2", 4'b0000, 16'hDEAD, 16'h0004, 1, 1, d, o);
    check("acc2_data", d, 16'h000B);
    check("acc_out", acc_out, 16'h000B);
    check("acc_count", op_count, 5);

    do_op("undef", 4'b1010, 16'h1234, 16'h5678, 0, 0, d, o);
    check("undef_data", d, 16'h0000);
    check("undef_func", alu_func, 4'b1010);

    bus.resp_ready = 1'b0;
    drive_req(4'b0100, 16'hF0F0, 16'hFF00, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive_req(4'b0101, 16'h0001, 16'h0002, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus.resp_valid, 1);
      check("bp_data", bus.resp_data, 16'hF000);
      check("bp_ready", bus.req_ready, 0);
      check("bp_func", alu_func, 4'b0100);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_rdy", bus.req_ready, 1);
    check("bp_count", op_count, 7);
    @(negedge clk);
    check("bp2_busy", bus.req_ready, 0);
    check("bp2_func", alu_func, 4'b0101);
    check("bp2_a", alu_a, 16'h0001);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("bp2_valid", bus.resp_valid, 1);
    check("bp2_data", bus.resp_data, 16'h0003);
    @(negedge clk);
    check("bp2_count", op_count, 8);

    drive_req(4'b0000, 16'h8000, 16'h8000, 0, 0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    sticky_clr    = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check("race_sticky", sticky_ovf, 1);
    check("race_data", bus.resp_data, 16'h0000);
    check("race_ovf", bus.resp_overflow, 1);
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check("late_clr", sticky_ovf, 0);

    drive_req(4'b0000, 16'h7FFF, 16'h0001, 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset_n       = 1'b0;
    #1;
    check("mid_valid", bus.resp_valid, 0);
    check("mid_ready", bus.req_ready, 1);
    check("mid_data", bus.resp_data, 0);
    check("mid_acc", acc_out, 0);
    check("mid_count", op_count, 0);
    check("mid_alu_a", alu_a, 0);
    check("mid_sticky", sticky_ovf, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) pulses++;
    end
    check("mid_no_resp", pulses, 0);
    check("mid_count_end", op_count, 0);
    check("mid_acc_end", acc_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator-side controller that drives the shared combinational 16-bit ALU (A, B, FuncCode in; C, OverflowFlag out).
- Accepts operation requests over a valid/ready handshake and registers the operands onto the ALU inputs.
- Captures the ALU result one cycle later and returns it over a valid/ready response port.
- Keeps an accumulator for chained operations, a sticky overflow flag and a completed-operation counter. It sits between the lab datapath/testbench and the ALU instance.

Parameters:
- data_width, 16, width of operands, result, accumulator and op counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_func  input  4  ALU function code, same encoding as the ALU FuncCode (ADD=4'b0000, SUB=4'b0001, ID=4'b0010, NOT=4'b0011, AND=4'b0100, OR=4'b0101, NAND=4'b0110, NOR=4'b0111).
- req_a  input  data_width  operand A.
- req_b  input  data_width  operand B.
- req_use_acc  input  1  1: ALU A operand is the accumulator and req_a is ignored.
- req_acc_wr  input  1  1: write the result into the accumulator on capture.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  data_width  captured ALU result.
- resp_overflow  output  1  captured ALU overflow.
- acc_out  output  data_width  current accumulator value.
- sticky_ovf  output  1  set by any captured overflow.
- sticky_clr  input  1  clears sticky_ovf.
- op_count  output  data_width  completed responses, saturating.
- alu_a  output  data_width  to ALU A.
- alu_b  output  data_width  to ALU B.
- alu_func  output  4  to ALU FuncCode.
- alu_c  input  data_width  from ALU C.
- alu_ovf  input  1  from ALU OverflowFlag.

Behaviour:
- Reset (asynchronous, reset_n low):
  - State returns to IDLE.
  - req_ready=1. resp_valid=0.
  - resp_data, resp_overflow, acc_out, sticky_ovf, op_count, alu_a, alu_b all 0.
  - alu_func=4'b0000.
  - Reset mid-operation discards the in-flight op; no response is emitted for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, register the operands to alu_a/alu_b/alu_func. alu_a takes acc_out when req_use_acc=1, else req_a.
  - Latch req_acc_wr and go to EXEC.
- EXEC:
  - req_ready=0.
  - ALU inputs are stable for this whole cycle.
  - At the cycle-end edge: capture alu_c into resp_data and alu_ovf into resp_overflow.
  - If the latched acc_wr=1, load acc_out<=alu_c.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_overflow are held stable until the handshake.
  - On resp_ready=1: return to IDLE and increment op_count. op_count saturates at all-ones and never wraps.
  - While resp_ready=0, stay in RESP; req_ready=0 (no new request accepted).
- Latency: handshake edge N, capture edge N+1, resp_valid high from N+1 until the response handshake. Minimum 3 cycles per op.
- alu_a/alu_b/alu_func hold their last values outside EXEC; no combinational path from req_* to alu_*.
- The accumulator is written only in EXEC with acc_wr=1. Chained ops see the updated value on the next request.
- sticky_ovf:
  - Set at the EXEC capture edge when alu_ovf=1.
  - sticky_clr=1 clears it in any state.
  - If clear and set coincide, set wins.
- The function code is passed through unchecked. Undefined codes yield whatever the ALU returns (0, no overflow).
- The req_valid level in EXEC/RESP is ignored; the requester must hold its request until req_ready.

Test Plan:
- Reset then ADD a=16'h7FFF b=16'h0001, resp_ready=1 -> resp_valid at cycle+2, resp_data=16'h8000, resp_overflow=1, sticky_ovf=1, op_count=1.
- SUB a=16'h0005 b=16'h0007 -> resp_data=16'hFFFE, resp_overflow=0, sticky_ovf unchanged.
- Accumulate:
  - ID a=16'h0003 acc_wr=1, then ADD use_acc=1 b=16'h0004 acc_wr=1, then same again.
  - Expect resp_data 3, 7, 11; acc_out=16'h000B.
  - req_a values on use_acc ops are ignored (drive 16'hDEAD).
- Backpressure:
  - Hold resp_ready=0 for 5 cycles with a new req_valid pending.
  - Expect resp_data stable, req_ready=0, no second issue.
  - After release, the second request is accepted the next cycle.
- Sticky flag: sticky_clr asserted on the same cycle as the EXEC capture of an overflowing ADD (16'h8000+16'h8000) -> sticky_ovf=1. sticky_clr alone later -> 0.
- Reset mid-operation:
  - Drop reset_n during EXEC.
  - Expect all outputs 0 immediately, with no resp_valid pulse after release.
  - op_count stays 0 and the accumulator is cleared.
